// File: rtl/imm_gen_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module   : imm_gen_pipe_if
//  Brief    : Handshake bundle for the immediate generator. The producer
//             side (fetch/decode) offers instructions. The consumer side
//             (execute) takes back sign-extended immediates.
//  Revision : 1.0  initial release
// ============================================================================
interface imm_gen_pipe_if #(
    parameter int N = 64
);
    // Instruction side
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_instr;

    // Result side
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_imm;
    logic [2:0]    out_fmt;
    logic          out_illegal;

    // Environment view: supplies instructions and consumes results
    modport master (
        output in_valid,
        output in_instr,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_imm,
        input  out_fmt,
        input  out_illegal
    );

    // Generator view
    modport slave (
        input  in_valid,
        input  in_instr,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_imm,
        output out_fmt,
        output out_illegal
    );
endinterface
`default_nettype wire

// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : imm_gen_pipe
//  Brief    : Two-stage RV32/RV64 immediate generator. It decodes the I, S,
//             B, U and J formats from the 7-bit opcode, assembles the
//             immediate and sign-extends it to N bits. The pipeline uses
//             valid/ready flow control and has a synchronous flush.
//             S1 holds the instruction and its format code. S2 holds the
//             finished immediate.
//  Revision : 1.0  initial release
// ============================================================================
module imm_gen_pipe #(
    parameter int N = 64
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        flush,
    imm_gen_pipe_if.slave    bus
);

    // ------------------------------------------------------------------------
    // Format codes presented on out_fmt
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_fmt_i    = 3'd0;
    localparam logic [2:0] c_fmt_s    = 3'd1;
    localparam logic [2:0] c_fmt_b    = 3'd2;
    localparam logic [2:0] c_fmt_u    = 3'd3;
    localparam logic [2:0] c_fmt_j    = 3'd4;
    localparam logic [2:0] c_fmt_none = 3'd7;

    // Only RV32 and RV64 data widths are meaningful
    if (N != 32 && N != 64) begin : g_bad_n
        $error("imm_gen_pipe: N must be 32 or 64");
    end

    // ------------------------------------------------------------------------
    // Opcode to format decode. Every 7-bit opcode is compared in full, so
    // custom or reserved opcodes fall through to "none".
    // ------------------------------------------------------------------------
    function automatic logic [2:0] decode_fmt(input logic [6:0] opcode);
        logic [2:0] fmt;
        case (opcode)
            7'b0000011,              // loads
            7'b0010011,              // OP-IMM
            7'b0011011,              // OP-IMM-32
            7'b1100111,              // JALR
            7'b1110011: fmt = c_fmt_i; // SYSTEM
            7'b0100011: fmt = c_fmt_s; // stores
            7'b1100011: fmt = c_fmt_b; // branches
            7'b0110111,              // LUI
            7'b0010111: fmt = c_fmt_u; // AUIPC
            7'b1101111: fmt = c_fmt_j; // JAL
            default:    fmt = c_fmt_none;
        endcase
        return fmt;
    endfunction

    // ------------------------------------------------------------------------
    // Pipeline state. The opcode is reduced to the format code in S1, so only
    // instruction bits [31:7] need to be kept.
    // ------------------------------------------------------------------------
    logic          r_s1_valid;
    logic [31:7]   r_s1_instr;
    logic [2:0]    r_s1_fmt;

    logic          r_s2_valid;
    logic [N-1:0]  r_out_imm;
    logic [2:0]    r_out_fmt;
    logic          r_out_illegal;

    // ------------------------------------------------------------------------
    // Handshake. A stage advances when it is empty or its successor advances.
    // in_ready is combinational from out_ready, so a full pipeline accepts
    // again in the same cycle that the consumer takes a result.
    // ------------------------------------------------------------------------
    logic w_s2_adv;
    logic w_s1_adv;
    logic w_in_ready;
    logic w_in_fire;

    assign w_s2_adv   = !r_s2_valid || bus.out_ready;
    assign w_s1_adv   = !r_s1_valid || w_s2_adv;
    assign w_in_ready = w_s1_adv && !flush;
    assign w_in_fire  = bus.in_valid && w_in_ready;

    // ------------------------------------------------------------------------
    // Immediate assembly at width N. Each immediate is sign-extended from
    // instruction bit 31.
    // ------------------------------------------------------------------------
    logic          w_sign;
    logic [N-1:0]  w_imm_i;
    logic [N-1:0]  w_imm_s;
    logic [N-1:0]  w_imm_b;
    logic [N-1:0]  w_imm_u;
    logic [N-1:0]  w_imm_j;

    assign w_sign  = r_s1_instr[31];

    assign w_imm_i = {{(N-12){w_sign}}, r_s1_instr[31:20]};

    assign w_imm_s = {{(N-12){w_sign}}, r_s1_instr[31:25], r_s1_instr[11:7]};

    assign w_imm_b = {{(N-13){w_sign}}, r_s1_instr[31], r_s1_instr[7],
                      r_s1_instr[30:25], r_s1_instr[11:8], 1'b0};

    assign w_imm_j = {{(N-21){w_sign}}, r_s1_instr[31], r_s1_instr[19:12],
                      r_s1_instr[20], r_s1_instr[30:21], 1'b0};

    // At N=32 the U immediate already fills the word, so it needs no extension
    if (N == 32) begin : g_u_native
        assign w_imm_u = {r_s1_instr[31:12], 12'b0};
    end else begin : g_u_extend
        assign w_imm_u = {{(N-32){w_sign}}, r_s1_instr[31:12], 12'b0};
    end

    // Select the immediate for the S1 format code. Illegal opcodes give zero.
    logic [N-1:0] w_imm_sel;

    always_comb begin
        w_imm_sel = '0;
        case (r_s1_fmt)
            c_fmt_i: w_imm_sel = w_imm_i;
            c_fmt_s: w_imm_sel = w_imm_s;
            c_fmt_b: w_imm_sel = w_imm_b;
            c_fmt_u: w_imm_sel = w_imm_u;
            c_fmt_j: w_imm_sel = w_imm_j;
            default: w_imm_sel = '0;
        endcase
    end

    // S1: capture the instruction and its format whenever the stage advances.
    // Flush clears only the valid bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_instr <= '0;
            r_s1_fmt   <= c_fmt_i;
        end else begin
            if (w_s1_adv) begin
                r_s1_instr <= bus.in_instr[31:7];
                r_s1_fmt   <= decode_fmt(bus.in_instr[6:0]);
                r_s1_valid <= w_in_fire;
            end
            if (flush) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    // S2: register the finished result. It holds while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid    <= 1'b0;
            r_out_imm     <= '0;
            r_out_fmt     <= c_fmt_i;
            r_out_illegal <= 1'b0;
        end else begin
            if (w_s2_adv) begin
                r_out_imm     <= w_imm_sel;
                r_out_fmt     <= r_s1_fmt;
                r_out_illegal <= (r_s1_fmt == c_fmt_none);
                r_s2_valid    <= r_s1_valid;
            end
            if (flush) begin
                r_s2_valid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = r_s2_valid;
    assign bus.out_imm     = r_out_imm;
    assign bus.out_fmt     = r_out_fmt;
    assign bus.out_illegal = r_out_illegal;

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imm_gen_pipe
//  Brief    : Scoreboard bench for imm_gen_pipe. It instantiates one N=64
//             instance and one N=32 instance. The stimulus pushes expected
//             results and per-DUT monitors pop and compare them.
//  Revision : 1.0  initial release
// ============================================================================
module tb_imm_gen_pipe;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic flush = 1'b0;
    int   cyc   = 0;

    always #5 clk = ~clk;

    // Cycle counter used to measure acceptance-to-output latency
    always @(posedge clk) cyc <= cyc + 1;

    imm_gen_pipe_if #(.N(64)) bus64 ();
    imm_gen_pipe_if #(.N(32)) bus32 ();

    imm_gen_pipe #(.N(64)) dut64 (.clk(clk), .rst(rst), .flush(flush), .bus(bus64));
    imm_gen_pipe #(.N(32)) dut32 (.clk(clk), .rst(rst), .flush(flush), .bus(bus32));

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t q64[$];
    exp_t q32[$];

    int n_pass = 0;
    int n_chk  = 0;

    logic [6:0] legal_ops [10] = '{7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111,
                                   7'b1110011, 7'b0100011, 7'b1100011, 7'b0110111,
                                   7'b0010111, 7'b1101111};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model written with arithmetic shifts on the sign-extended word
    function automatic void ref_model(input logic [31:0] ins, output logic [63:0] imm,
                                      output logic [2:0] fmt);
        logic signed [63:0] s;
        logic [63:0] t12, t20, t25, t31;
        s   = $signed({{32{ins[31]}}, ins});
        t12 = s >>> 12;
        t20 = s >>> 20;
        t25 = s >>> 25;
        t31 = s >>> 31;
        imm = 64'd0;
        fmt = 3'd7;
        case (ins[6:0])
            7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111, 7'b1110011: begin
                fmt = 3'd0; imm = t20;
            end
            7'b0100011: begin
                fmt = 3'd1; imm = (t25 << 5) | 64'(ins[11:7]);
            end
            7'b1100011: begin
                fmt = 3'd2;
                imm = (t31 << 12) | (64'(ins[7]) << 11) | (64'(ins[30:25]) << 5)
                    | (64'(ins[11:8]) << 1);
            end
            7'b0110111, 7'b0010111: begin
                fmt = 3'd3; imm = t12 << 12;
            end
            7'b1101111: begin
                fmt = 3'd4;
                imm = (t31 << 20) | (64'(ins[19:12]) << 12) | (64'(ins[20]) << 11)
                    | (64'(ins[30:21]) << 1);
            end
            default: begin
                fmt = 3'd7; imm = 64'd0;
            end
        endcase
    endfunction

    // Monitor for the N=64 instance: pop and compare on every output transfer
    always @(negedge clk) begin : mon64
        exp_t e;
        if (!rst && bus64.out_valid && bus64.out_ready) begin
            if (q64.size() == 0) begin
                n_chk++;
                $display("FAIL out64_unexpected: got imm 0x%0h, expected no output", bus64.out_imm);
            end else begin
                e = q64.pop_front();
                check("out64_imm", bus64.out_imm, e.imm);
                check("out64_fmt", 64'(bus64.out_fmt), 64'(e.fmt));
                check("out64_illegal", 64'(bus64.out_illegal), 64'(e.ill));
                if (e.lat) check("out64_latency", 64'(cyc - e.acc), 64'd2);
            end
        end
    end

    // Monitor for the N=32 instance
    always @(negedge clk) begin : mon32
        exp_t e;
        if (!rst && bus32.out_valid && bus32.out_ready) begin
            if (q32.size() == 0) begin
                n_chk++;
                $display("FAIL out32_unexpected: got imm 0x%0h, expected no output", bus32.out_imm);
            end else begin
                e = q32.pop_front();
                check("out32_imm", {32'd0, bus32.out_imm}, e.imm);
                check("out32_fmt", 64'(bus32.out_fmt), 64'(e.fmt));
                check("out32_illegal", 64'(bus32.out_illegal), 64'(e.ill));
                if (e.lat) check("out32_latency", 64'(cyc - e.acc), 64'd2);
            end
        end
    end

    // Offer one instruction, starting and ending just after a rising edge.
    // The expected result is queued at the cycle the DUT accepts it.
    task automatic send(input bit s32, input logic [31:0] instr, input logic [63:0] eimm,
                        input logic [2:0] efmt, input bit lat, input bit must_ready);
        exp_t e;
        int   w;
        logic rdy;
        e.imm = eimm;
        e.fmt = efmt;
        e.ill = (efmt == 3'd7);
        e.lat = lat;
        e.acc = 0;
        if (s32) begin bus32.in_valid = 1'b1; bus32.in_instr = instr; end
        else     begin bus64.in_valid = 1'b1; bus64.in_instr = instr; end
        w = 0;
        forever begin
            @(negedge clk);
            rdy = s32 ? bus32.in_ready : bus64.in_ready;
            if (must_ready && w == 0) check("in_ready_on_offer", 64'(rdy), 64'd1);
            if (rdy) begin
                e.acc = cyc;
                if (s32) q32.push_back(e); else q64.push_back(e);
                @(posedge clk); #1;
                break;
            end
            w++;
            if (w > 40) begin
                n_chk++;
                $display("FAIL accept_timeout: instr 0x%0h not accepted, expected acceptance", instr);
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
        if (s32) bus32.in_valid = 1'b0; else bus64.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Time limit: never hang
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [31:0] r, ins;
        logic [63:0] eimm;
        logic [2:0]  efmt;

        bus64.in_valid = 1'b0; bus64.in_instr = '0; bus64.out_ready = 1'b1;
        bus32.in_valid = 1'b0; bus32.in_instr = '0; bus32.out_ready = 1'b1;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(bus64.out_valid), 64'd0);
        check("rst_out_imm", bus64.out_imm, 64'd0);
        check("rst_out_fmt", 64'(bus64.out_fmt), 64'd0);
        check("rst_out_illegal", 64'(bus64.out_illegal), 64'd0);
        check("rst32_out_valid", 64'(bus32.out_valid), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 64'(bus64.in_ready), 64'd1);
        check("rst32_in_ready", 64'(bus32.in_ready), 64'd1);
        @(posedge clk); #1;

        // Single-format decode, N=64
        send(0, 32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 3'd0, 1, 1); idle(3);
        send(0, 32'hFE112E23, 64'hFFFF_FFFF_FFFF_FFFC, 3'd1, 1, 1); idle(3);
        send(0, 32'hFE000EE3, 64'hFFFF_FFFF_FFFF_FFFC, 3'd2, 1, 1); idle(3);
        send(0, 32'h800000B7, 64'hFFFF_FFFF_8000_0000, 3'd3, 1, 1); idle(3);
        send(0, 32'hFFDFF0EF, 64'hFFFF_FFFF_FFFF_FFFC, 3'd4, 1, 1); idle(3);

        // Illegal opcode followed by a normal instruction
        send(0, 32'h0000007F, 64'd0, 3'd7, 1, 1);
        send(0, 32'h00500093, 64'd5, 3'd0, 1, 1);
        idle(3);

        // Back-to-back random legal stream
        for (int i = 0; i < 20; i++) begin
            r   = $urandom();
            ins = {r[31:7], legal_ops[$urandom_range(0, 9)]};
            ref_model(ins, eimm, efmt);
            send(0, ins, eimm, efmt, 1, 1);
        end
        idle(3);

        // Backpressure: two accepted, then in_ready low while results hold
        bus64.out_ready = 1'b0;
        send(0, 32'h00100093, 64'd1, 3'd0, 0, 1);
        send(0, 32'h7E000FA3, 64'd2047, 3'd1, 0, 1);
        bus64.in_valid = 1'b1;
        bus64.in_instr = 32'h12345037;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready_low", 64'(bus64.in_ready), 64'd0);
            check("bp_out_valid", 64'(bus64.out_valid), 64'd1);
            check("bp_out_imm_stable", bus64.out_imm, 64'd1);
            check("bp_out_fmt_stable", 64'(bus64.out_fmt), 64'd0);
            @(posedge clk); #1;
        end
        bus64.out_ready = 1'b1;
        send(0, 32'h12345037, 64'h0000_0000_1234_5000, 3'd3, 0, 1);
        idle(4);

        // Flush with the pipeline full and an input offered
        bus64.out_ready = 1'b0;
        send(0, 32'h00200093, 64'd2, 3'd0, 0, 1);
        send(0, 32'h00300093, 64'd3, 3'd0, 0, 1);
        flush = 1'b1;
        bus64.in_valid  = 1'b1;
        bus64.in_instr  = 32'h00400093;
        bus64.out_ready = 1'b1;
        @(negedge clk);
        check("flush_in_ready", 64'(bus64.in_ready), 64'd0);
        @(posedge clk); #1;
        q64.delete();
        flush = 1'b0;
        bus64.in_valid = 1'b0;
        @(negedge clk);
        check("flush_out_valid", 64'(bus64.out_valid), 64'd0);
        @(posedge clk); #1;
        send(0, 32'hFE112E23, 64'hFFFF_FFFF_FFFF_FFFC, 3'd1, 1, 1);
        idle(4);

        // Reset mid-stream for one cycle
        bus64.out_ready = 1'b0;
        send(0, 32'h00500093, 64'd5, 3'd0, 0, 1);
        send(0, 32'hFFDFF0EF, 64'hFFFF_FFFF_FFFF_FFFC, 3'd4, 0, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        q64.delete();
        rst = 1'b0;
        check("mid_rst_out_valid", 64'(bus64.out_valid), 64'd0);
        check("mid_rst_out_imm", bus64.out_imm, 64'd0);
        check("mid_rst_out_fmt", 64'(bus64.out_fmt), 64'd0);
        check("mid_rst_out_illegal", 64'(bus64.out_illegal), 64'd0);
        bus64.out_ready = 1'b1;
        @(negedge clk);
        check("mid_rst_in_ready", 64'(bus64.in_ready), 64'd1);
        @(posedge clk); #1;
        send(0, 32'h800000B7, 64'hFFFF_FFFF_8000_0000, 3'd3, 1, 1);
        idle(3);

        // Decode with N=32
        send(1, 32'h800000B7, 64'h0000_0000_8000_0000, 3'd3, 1, 1);
        send(1, 32'hFFDFF0EF, 64'h0000_0000_FFFF_FFFC, 3'd4, 1, 1);
        send(1, 32'hFFF00093, 64'h0000_0000_FFFF_FFFF, 3'd0, 1, 1);
        send(1, 32'h0000007F, 64'd0, 3'd7, 1, 1);
        idle(6);

        // Every queued result must have emerged
        check("drain_q64_empty", 64'(q64.size()), 64'd0);
        check("drain_q32_empty", 64'(q32.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
